tdm_demux: RTL

- Receive-side counterpart to the team's mux path.
- Accepts a serial time-division-multiplexed bit stream and locks to a frame marker.
- Distributes each WIDTH-bit slot, MSB first, to one of CHANNELS parallel output registers.
- Sits between a serial link and per-channel consumers. Raises a per-channel strobe whenever a channel's word updates.

---
 rtl/tdm_demux.sv | 135 +++++++++++++
 1 files changed

// File: rtl/tdm_demux.sv
// Serial TDM receiver: locks onto frame_sync and steers each MSB-first slot
// into its own parallel output word, with per-channel and per-frame strobes.
//
// state | meaning
// HUNT  | unlocked; bits discarded until a bit arrives with frame_sync
// LOCK  | aligned; bits assembled into slots, sync checked at slot 0 bit 0
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  input  logic                      din_en,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       ch_valid,
  output logic                      frame_done,
  output logic                      sync_err,
  output logic                      locked
);

  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SRW = WIDTH - 1;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [BW-1:0]             bit_cnt, bit_cnt_nxt;
  logic [SW-1:0]             slot, slot_nxt;
  logic [SRW-1:0]            shreg, shreg_nxt;
  logic [CHANNELS*WIDTH-1:0] dout_nxt;
  logic [CHANNELS-1:0]       ch_valid_nxt;
  logic                      frame_done_nxt;
  logic                      sync_err_nxt;
  logic [WIDTH-1:0]          word;
  logic                      at_frame_start;
  logic                      word_end;
  logic                      last_slot;

  // Only WIDTH-1 bits are stored: the final bit of a word goes straight to dout.
  assign word           = {shreg, din};
  assign at_frame_start = (slot == '0) && (bit_cnt == '0);
  assign word_end       = (bit_cnt == BW'(WIDTH - 1));
  assign last_slot      = (slot == SW'(CHANNELS - 1));
  assign locked         = (state == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      bit_cnt    <= '0;
      slot       <= '0;
      shreg      <= '0;
      dout       <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      slot       <= slot_nxt;
      shreg      <= shreg_nxt;
      dout       <= dout_nxt;
      ch_valid   <= ch_valid_nxt;
      frame_done <= frame_done_nxt;
      sync_err   <= sync_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    slot_nxt       = slot;
    shreg_nxt      = shreg;
    dout_nxt       = dout;
    ch_valid_nxt   = '0;
    frame_done_nxt = 1'b0;
    sync_err_nxt   = 1'b0;

    if (din_en) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            state_nxt   = LOCK;
            shreg_nxt   = SRW'(din);
            bit_cnt_nxt = BW'(1);
            slot_nxt    = '0;
          end
        end

        LOCK: begin
          if (at_frame_start && !frame_sync) begin
            // Missing marker: drop lock and this bit.
            sync_err_nxt = 1'b1;
            state_nxt    = HUNT;
            shreg_nxt    = '0;
            bit_cnt_nxt  = '0;
            slot_nxt     = '0;
          end else if (!at_frame_start && frame_sync) begin
            // Early marker: abandon the partial word, realign on this bit.
            sync_err_nxt = 1'b1;
            shreg_nxt    = SRW'(din);
            bit_cnt_nxt  = BW'(1);
            slot_nxt     = '0;
          end else if (word_end) begin
            dout_nxt[int'(slot)*WIDTH +: WIDTH] = word;
            ch_valid_nxt[slot]                  = 1'b1;
            shreg_nxt                           = '0;
            bit_cnt_nxt                         = '0;
            if (last_slot) begin
              slot_nxt       = '0;
              frame_done_nxt = 1'b1;
            end else begin
              slot_nxt = slot + SW'(1);
            end
          end else begin
            shreg_nxt   = word[SRW-1:0];
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end

        default: begin
          state_nxt   = HUNT;
          bit_cnt_nxt = '0;
          slot_nxt    = '0;
        end
      endcase
    end
  end

endmodule
